// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared types, constants and helpers for the MM:SS BCD countdown timer.
//   state_t          : controller state (IDLE/RUN/PAUSED/EXPIRED), 2-bit
//   BCD_MAX_UNITS    : largest legal BCD units digit (9)
//   BCD_MAX_SEC_TENS : largest legal seconds tens digit (5)
//   clamp()          : saturates a digit to a maximum legal value
// -----------------------------------------------------------------------------
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX_UNITS    = 4'd9;
    localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

    function automatic logic [3:0] clamp(input logic [3:0] digit, input logic [3:0] maxv);
        return (digit > maxv) ? maxv : digit;
    endfunction

endpackage

// File: rtl/bcd_digit_down.sv
// -----------------------------------------------------------------------------
// bcd_digit_down
// One BCD digit of a down-counter. Purely combinational: given the current
// digit and a decrement enable, produces the next digit and a borrow for the
// next more-significant digit. Wraps 0 -> MAXV when decremented.
//   digit_i  : current digit value
//   dec_en_i : decrement this digit (borrow from the less-significant digit)
//   digit_o  : next digit value
//   borrow_o : high when digit_i == 0 and dec_en_i is high
// -----------------------------------------------------------------------------
module bcd_digit_down
    import timer_pkg::*;
#(
    parameter logic [3:0] MAXV = BCD_MAX_UNITS
) (
    input  logic [3:0] digit_i,
    input  logic       dec_en_i,
    output logic [3:0] digit_o,
    output logic       borrow_o
);

    always_comb begin
        borrow_o = dec_en_i && (digit_i == 4'd0);
        if (!dec_en_i) begin
            digit_o = digit_i;
        end else if (digit_i == 4'd0) begin
            digit_o = MAXV;
        end else begin
            digit_o = digit_i - 4'd1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// MM:SS BCD countdown timer. TICK_IN is the divided clock level, sampled as
// data in the CLK domain; each rising edge removes one second while running.
// Optional feature macro: TIMER_AUTO_RELOAD_EN (reload last loaded value on
// expiry and keep running).
//   CLK      : system clock
//   RST_N    : asynchronous active-low reset
//   TICK_IN  : divided clock level (edge-detected internally)
//   LOAD     : strobe, loads LOAD_MIN/LOAD_SEC (sanitised) when not running
//   LOAD_MIN : BCD minutes to load
//   LOAD_SEC : BCD seconds to load
//   START    : strobe, starts/resumes the countdown
//   PAUSE    : strobe, pauses the countdown
//   MIN/SEC  : current BCD minutes/seconds (registered)
//   RUNNING  : high while in RUN (registered)
//   DONE     : one-cycle pulse on expiry (registered)
// -----------------------------------------------------------------------------
module countdown_timer
    import timer_pkg::*;
#(
    parameter logic [7:0] INIT_MIN = 8'h01,
    parameter logic [7:0] INIT_SEC = 8'h30
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       TICK_IN,
    input  logic       LOAD,
    input  logic [7:0] LOAD_MIN,
    input  logic [7:0] LOAD_SEC,
    input  logic       START,
    input  logic       PAUSE,
    output logic [7:0] MIN,
    output logic [7:0] SEC,
    output logic       RUNNING,
    output logic       DONE
);

    state_t     state_q;
    logic       tick_d_q;
    logic       tick_q;
    logic [7:0] min_q;
    logic [7:0] sec_q;
    logic       running_q;
    logic       done_q;
`ifdef TIMER_AUTO_RELOAD_EN
    logic [7:0] rld_min_q;
    logic [7:0] rld_sec_q;
`endif

    logic       run_tick;
    logic [7:0] min_dec;
    logic [7:0] sec_dec;
    logic       b_su, b_st, b_mu, b_mt;
    logic [7:0] load_min_s;
    logic [7:0] load_sec_s;
    logic       count_zero;
    logic       expire;

    // tick_q is the registered rising-edge pulse, so the count moves on the
    // second CLK edge after TICK_IN is first sampled high. PAUSE in the same
    // cycle swallows the tick.
    assign run_tick = (state_q == ST_RUN) && tick_q && !PAUSE;

    bcd_digit_down #(.MAXV(BCD_MAX_UNITS)) u_sec_units (
        .digit_i(sec_q[3:0]), .dec_en_i(run_tick), .digit_o(sec_dec[3:0]), .borrow_o(b_su)
    );
    bcd_digit_down #(.MAXV(BCD_MAX_SEC_TENS)) u_sec_tens (
        .digit_i(sec_q[7:4]), .dec_en_i(b_su), .digit_o(sec_dec[7:4]), .borrow_o(b_st)
    );
    bcd_digit_down #(.MAXV(BCD_MAX_UNITS)) u_min_units (
        .digit_i(min_q[3:0]), .dec_en_i(b_st), .digit_o(min_dec[3:0]), .borrow_o(b_mu)
    );
    bcd_digit_down #(.MAXV(BCD_MAX_UNITS)) u_min_tens (
        .digit_i(min_q[7:4]), .dec_en_i(b_mu), .digit_o(min_dec[7:4]), .borrow_o(b_mt)
    );

    assign load_min_s = {clamp(LOAD_MIN[7:4], BCD_MAX_UNITS), clamp(LOAD_MIN[3:0], BCD_MAX_UNITS)};
    assign load_sec_s = {clamp(LOAD_SEC[7:4], BCD_MAX_SEC_TENS), clamp(LOAD_SEC[3:0], BCD_MAX_UNITS)};

    assign count_zero = (min_q == 8'h00) && (sec_q == 8'h00);
    // Reaching 00:00 expires; a borrow out of the top digit (decrementing an
    // already-zero count) is treated the same way so the count never wraps.
    assign expire = run_tick && (((min_dec == 8'h00) && (sec_dec == 8'h00)) || b_mt);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            tick_d_q  <= 1'b0;
            tick_q    <= 1'b0;
            min_q     <= INIT_MIN;
            sec_q     <= INIT_SEC;
            running_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef TIMER_AUTO_RELOAD_EN
            rld_min_q <= INIT_MIN;
            rld_sec_q <= INIT_SEC;
`endif
        end else begin
            tick_d_q <= TICK_IN;
            tick_q   <= TICK_IN && !tick_d_q;
            done_q   <= 1'b0;

            case (state_q)
                ST_IDLE, ST_PAUSED, ST_EXPIRED: begin
                    if (LOAD) begin
                        min_q     <= load_min_s;
                        sec_q     <= load_sec_s;
`ifdef TIMER_AUTO_RELOAD_EN
                        rld_min_q <= load_min_s;
                        rld_sec_q <= load_sec_s;
`endif
                        state_q   <= ST_IDLE;
                        running_q <= 1'b0;
                    end else if (START && (state_q != ST_EXPIRED)) begin
                        if (count_zero) begin
                            state_q <= ST_EXPIRED;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= ST_RUN;
                            running_q <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (PAUSE) begin
                        state_q   <= ST_PAUSED;
                        running_q <= 1'b0;
                    end else if (expire) begin
                        done_q <= 1'b1;
`ifdef TIMER_AUTO_RELOAD_EN
                        if ((rld_min_q != 8'h00) || (rld_sec_q != 8'h00)) begin
                            min_q <= rld_min_q;
                            sec_q <= rld_sec_q;
                        end else begin
                            min_q     <= 8'h00;
                            sec_q     <= 8'h00;
                            state_q   <= ST_EXPIRED;
                            running_q <= 1'b0;
                        end
`else
                        min_q     <= 8'h00;
                        sec_q     <= 8'h00;
                        state_q   <= ST_EXPIRED;
                        running_q <= 1'b0;
`endif
                    end else if (run_tick) begin
                        min_q <= min_dec;
                        sec_q <= sec_dec;
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign MIN     = min_q;
    assign SEC     = sec_q;
    assign RUNNING = running_q;
    assign DONE    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
// Self-checking bench for countdown_timer. The reference keeps the count as a
// plain number of seconds plus running/expired flags and converts to BCD only
// for comparison.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       TICK_IN, LOAD, START, PAUSE;
    logic [7:0] LOAD_MIN, LOAD_SEC;
    logic [7:0] MIN, SEC;
    logic       RUNNING, DONE;

    int checks = 0;
    int errors = 0;

    countdown_timer #(.INIT_MIN(8'h01), .INIT_SEC(8'h30)) dut (
        .CLK(CLK), .RST_N(RST_N), .TICK_IN(TICK_IN), .LOAD(LOAD),
        .LOAD_MIN(LOAD_MIN), .LOAD_SEC(LOAD_SEC), .START(START), .PAUSE(PAUSE),
        .MIN(MIN), .SEC(SEC), .RUNNING(RUNNING), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // reference state
    int m_total;
    int m_reload;
    bit m_running;
    bit m_expired;
    bit m_done;
    bit m_prev;
    bit m_tick_pend;

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int clampd(input int d, input int maxv);
        return (d > maxv) ? maxv : d;
    endfunction

    function automatic int load_value(input logic [7:0] lm, input logic [7:0] ls);
        int mins, secs;
        mins = clampd(int'(lm[7:4]), 9) * 10 + clampd(int'(lm[3:0]), 9);
        secs = clampd(int'(ls[7:4]), 5) * 10 + clampd(int'(ls[3:0]), 9);
        return mins * 60 + secs;
    endfunction

    task automatic model_reset();
        m_total = 90; m_reload = 90;
        m_running = 0; m_expired = 0; m_done = 0;
        m_prev = 0; m_tick_pend = 0;
    endtask

    task automatic model_clock(input bit ld, input logic [7:0] lm, input logic [7:0] ls,
                               input bit st, input bit pa, input bit ti);
        bit tick_now;
        tick_now    = m_tick_pend;
        m_tick_pend = ti && !m_prev;
        m_prev      = ti;
        m_done      = 0;
        if (m_running) begin
            if (pa) begin
                m_running = 0;
            end else if (tick_now) begin
                m_total = m_total - 1;
                if (m_total <= 0) begin
                    m_total = 0;
                    m_done  = 1;
`ifdef TIMER_AUTO_RELOAD_EN
                    if (m_reload != 0) m_total = m_reload;
                    else begin m_running = 0; m_expired = 1; end
`else
                    m_running = 0; m_expired = 1;
`endif
                end
            end
        end else if (ld) begin
            m_total = load_value(lm, ls);
            m_reload = m_total;
            m_expired = 0;
        end else if (st && !m_expired) begin
            if (m_total == 0) begin m_expired = 1; m_done = 1; end
            else m_running = 1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_min"}, MIN, to_bcd(m_total / 60));
        check({tag, "_sec"}, SEC, to_bcd(m_total % 60));
        check({tag, "_run"}, {7'd0, RUNNING}, {7'd0, m_running});
        check({tag, "_done"}, {7'd0, DONE}, {7'd0, m_done});
    endtask

    task automatic step(input bit ld, input logic [7:0] lm, input logic [7:0] ls,
                        input bit st, input bit pa, input bit ti);
        @(negedge CLK);
        LOAD = ld; LOAD_MIN = lm; LOAD_SEC = ls; START = st; PAUSE = pa; TICK_IN = ti;
        @(posedge CLK);
        #1;
        model_clock(ld, lm, ls, st, pa, ti);
        check_all("step");
    endtask

    task automatic idle();            step(0, 8'h00, 8'h00, 0, 0, 0); endtask
    task automatic do_start();        step(0, 8'h00, 8'h00, 1, 0, 0); endtask
    task automatic do_pause();        step(0, 8'h00, 8'h00, 0, 1, 0); endtask
    task automatic do_load(input logic [7:0] lm, input logic [7:0] ls); step(1, lm, ls, 0, 0, 0); endtask
    // rising edge on one step, the decrement lands on the following step
    task automatic do_tick();         step(0, 8'h00, 8'h00, 0, 0, 1); idle(); endtask

    initial begin
        bit ti_r;
        RST_N = 1'b0; TICK_IN = 0; LOAD = 0; START = 0; PAUSE = 0;
        LOAD_MIN = 8'h00; LOAD_SEC = 8'h00;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        check("rst_min", MIN, 8'h01);
        check("rst_sec", SEC, 8'h30);
        check("rst_run", {7'd0, RUNNING}, 8'h00);
        check("rst_done", {7'd0, DONE}, 8'h00);
        @(negedge CLK);
        RST_N = 1'b1;

        // start from defaults, three ticks
        do_start();
        do_tick(); do_tick(); do_tick();
        check("three_ticks_sec", SEC, 8'h27);
        check("three_ticks_min", MIN, 8'h01);

        // tick latency: no change one edge after TICK_IN high, change on the next
        step(0, 8'h00, 8'h00, 0, 0, 1);
        check("lat_hold", SEC, 8'h27);
        idle();
        check("lat_upd", SEC, 8'h26);

        // expiry from 00:01
        do_pause();
        do_load(8'h00, 8'h01);
        do_start();
        step(0, 8'h00, 8'h00, 0, 0, 1);
        idle();
        check("exp_done", {7'd0, DONE}, 8'h01);
        check("exp_sec", SEC, 8'h00);
`ifndef TIMER_AUTO_RELOAD_EN
        check("exp_run", {7'd0, RUNNING}, 8'h00);
`endif
        idle();
        check("exp_done_gone", {7'd0, DONE}, 8'h00);
        do_tick(); do_tick();
        do_start();
        check("exp_start_ign", {7'd0, RUNNING}, {7'd0, m_running});

        // borrow across both digits
        do_pause();
        do_load(8'h01, 8'h00);
        do_start();
        do_tick();
        check("borrow_min", MIN, 8'h00);
        check("borrow_sec", SEC, 8'h59);

        // pause coinciding with tick discards the tick
        do_pause();
        do_load(8'h00, 8'h45);
        do_start();
        step(0, 8'h00, 8'h00, 0, 0, 1);
        step(0, 8'h00, 8'h00, 0, 1, 0);
        check("pause_tick_sec", SEC, 8'h45);
        check("pause_tick_run", {7'd0, RUNNING}, 8'h00);
        repeat (5) do_tick();
        check("paused_hold", SEC, 8'h45);
        do_start();
        do_tick();
        check("resume_sec", SEC, 8'h44);

        // level held high yields one decrement
        repeat (20) step(0, 8'h00, 8'h00, 0, 0, 1);
        idle();
        check("held_sec", SEC, 8'h43);

        // load sanitising
        do_pause();
        do_load(8'h00, 8'h7C);
        check("clamp_sec", SEC, 8'h59);
        do_load(8'hAF, 8'hF3);
        check("clamp_min2", MIN, 8'h99);
        check("clamp_sec2", SEC, 8'h53);

`ifdef TIMER_AUTO_RELOAD_EN
        do_load(8'h00, 8'h02);
        do_start();
        do_tick();
        step(0, 8'h00, 8'h00, 0, 0, 1);
        idle();
        check("arl_done", {7'd0, DONE}, 8'h01);
        check("arl_sec", SEC, 8'h02);
        check("arl_run", {7'd0, RUNNING}, 8'h01);
        do_pause();
`endif

        // asynchronous reset mid-run
        do_load(8'h05, 8'h00);
        do_start();
        do_tick(); do_tick();
        #2;
        RST_N = 1'b0;
        #1;
        check("arst_min", MIN, 8'h01);
        check("arst_sec", SEC, 8'h30);
        check("arst_run", {7'd0, RUNNING}, 8'h00);
        check("arst_done", {7'd0, DONE}, 8'h00);
        model_reset();
        TICK_IN = 0; LOAD = 0; START = 0; PAUSE = 0;
        @(negedge CLK);
        RST_N = 1'b1;

        // randomized traffic against the reference
        ti_r = 0;
        for (int i = 0; i < 1500; i++) begin
            bit ld, st, pa;
            logic [7:0] lm, ls;
            ld = ($urandom_range(15, 0) == 0);
            st = ($urandom_range(5, 0) == 0);
            pa = ($urandom_range(40, 0) == 0);
            lm = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 0)) : 8'h00;
            ls = 8'($urandom_range(255, 0));
            if ($urandom_range(2, 0) == 0) ti_r = !ti_r;
            step(ld, lm, ls, st, pa, ti_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
